// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : regfile_mp
// Description : Parametrised multi-port register file with two write ports
//               (ALU writeback, load return), combinational read ports and a
//               per-register busy scoreboard. Optional same-cycle write-to-read
//               forwarding is enabled by defining REGFILE_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2,
    parameter int ZERO_REG   = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           we0,
    input  logic [ADDR_WIDTH-1:0]          wa0,
    input  logic [DATA_WIDTH-1:0]          wd0,
    input  logic                           we1,
    input  logic [ADDR_WIDTH-1:0]          wa1,
    input  logic [DATA_WIDTH-1:0]          wd1,
    input  logic                           set_busy,
    input  logic [ADDR_WIDTH-1:0]          set_addr,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] ra,
    output logic [NUM_READ*DATA_WIDTH-1:0] rd,
    output logic [NUM_READ-1:0]            rd_busy,
    output logic                           any_busy
);

    localparam int                    c_DEPTH     = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] c_ZERO_ADDR = '0;
    localparam bit                    c_HAS_ZERO  = (ZERO_REG != 0);

    logic [DATA_WIDTH-1:0] r_regs [c_DEPTH];
    logic [c_DEPTH-1:0]    r_busy;

    logic w_we0_ok;
    logic w_we1_ok;
    logic w_set_ok;

    // Anything aimed at the hardwired zero register is discarded up front.
    assign w_we0_ok = we0      && !(c_HAS_ZERO && (wa0      == c_ZERO_ADDR));
    assign w_we1_ok = we1      && !(c_HAS_ZERO && (wa1      == c_ZERO_ADDR));
    assign w_set_ok = set_busy && !(c_HAS_ZERO && (set_addr == c_ZERO_ADDR));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_regs[i] <= '0;
            end
            r_busy <= '0;
        end else begin
            for (int i = 0; i < c_DEPTH; i++) begin
                // Port 0 carries the younger instruction, so it wins a collision.
                if (w_we0_ok && (wa0 == ADDR_WIDTH'(i))) begin
                    r_regs[i] <= wd0;
                end else if (w_we1_ok && (wa1 == ADDR_WIDTH'(i))) begin
                    r_regs[i] <= wd1;
                end
                // A freshly issued load outranks the return of the previous one.
                if (w_set_ok && (set_addr == ADDR_WIDTH'(i))) begin
                    r_busy[i] <= 1'b1;
                end else if (we1 && (wa1 == ADDR_WIDTH'(i))) begin
                    r_busy[i] <= 1'b0;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_READ; g++) begin : g_read
        logic [ADDR_WIDTH-1:0] w_ra;
        logic [DATA_WIDTH-1:0] w_data;
        logic                  w_busy;

        assign w_ra = ra[g*ADDR_WIDTH +: ADDR_WIDTH];

        always_comb begin
            w_data = r_regs[w_ra];
            w_busy = r_busy[w_ra];
`ifdef REGFILE_BYPASS_EN
            if (w_we0_ok && (wa0 == w_ra)) begin
                w_data = wd0;
            end else if (w_we1_ok && (wa1 == w_ra)) begin
                w_data = wd1;
                w_busy = 1'b0;
            end
`endif
            if (c_HAS_ZERO && (w_ra == c_ZERO_ADDR)) begin
                w_data = '0;
                w_busy = 1'b0;
            end
            // Outputs collapse to zero the instant reset asserts.
            if (!rst_n) begin
                w_data = '0;
                w_busy = 1'b0;
            end
        end

        assign rd[g*DATA_WIDTH +: DATA_WIDTH] = w_data;
        assign rd_busy[g]                     = w_busy;
    end

    assign any_busy = rst_n && (|r_busy);

endmodule
`default_nettype wire

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file for the RISC-V core. Generalises the current 2-read/1-write RegFile in data width, depth and number of read ports.
- Adds a second write port for late-returning load data.
- Adds a per-register busy scoreboard so decode can stall on in-flight loads.
- Sits between decode (read ports, busy query) and writeback (two write ports).

Parameters:
DATA_WIDTH, 32, width of each register in bits
ADDR_WIDTH, 5, register address width; depth = 2**ADDR_WIDTH
NUM_READ, 2, number of independent read ports (1..4)
ZERO_REG, 1, 1 = register 0 hardwired to zero and never busy; 0 = register 0 is ordinary storage

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
we0  in  1  write enable, primary (ALU) writeback port
wa0  in  ADDR_WIDTH  write address, port 0
wd0  in  DATA_WIDTH  write data, port 0
we1  in  1  write enable, load-return port; also clears the busy bit
wa1  in  ADDR_WIDTH  write address, port 1
wd1  in  DATA_WIDTH  write data, port 1
set_busy  in  1  mark register set_addr as pending a load return
set_addr  in  ADDR_WIDTH  register to mark busy
ra  in  NUM_READ*ADDR_WIDTH  packed read addresses; port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
rd  out  NUM_READ*DATA_WIDTH  packed read data; same packing as ra
rd_busy  out  NUM_READ  busy flag of the register addressed by each read port
any_busy  out  1  OR of all busy bits

Behaviour:
- Reset is asynchronous and active-low. While rst_n = 0:
  - all registers are 0 and all busy bits are 0.
  - outputs are immediately rd = 0, rd_busy = 0, any_busy = 0.
  - writes and set_busy are ignored.
- Writes:
  - Take effect on the rising clk edge; new data is readable the cycle after.
  - If we0 and we1 target the same address in one cycle, port 0 data is stored and port 1 data is dropped. Port 0 is the younger instruction.
  - The busy clear from port 1 still applies in that case.
- Reads:
  - Combinational (asynchronous), zero latency: rd[i] = reg[ra[i]] in the same cycle.
  - Any number of read ports may address the same register.
- Scoreboard:
  - busy[set_addr] <= 1 on the edge when set_busy = 1.
  - busy[wa1] <= 0 on the edge when we1 = 1.
  - Port 0 writes never touch busy bits.
  - If set_busy and we1 hit the same address in one cycle, set wins: busy stays or becomes 1. A new load has been issued to that register.
  - set_busy to an already-busy register leaves it busy. There is no counting; one return clears it.
  - rd_busy[i] = busy[ra[i]], combinational.
- Zero register (ZERO_REG = 1):
  - Writes to address 0 on either port are discarded.
  - set_busy to address 0 is discarded.
  - Reads of address 0 return 0 with rd_busy = 0.
- Reset asserted mid-operation: all pending busy bits and data are lost immediately. Writes in flight on that edge are not stored.
- Depth wrap: addresses are exactly ADDR_WIDTH wide, so no out-of-range case exists.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: same-cycle write-to-read forwarding.
  - If we0 = 1 and wa0 = ra[i], then rd[i] = wd0.
  - Otherwise, if we1 = 1 and wa1 = ra[i], then rd[i] = wd1 and rd_busy[i] = 0. The returning load resolves the stall that cycle.
  - Port 0 takes priority over port 1.
  - Never applies to address 0 when ZERO_REG = 1.
- Undefined: reads return the pre-edge stored value. rd_busy reflects the stored busy bit only.

Test Plan:
- Reset then read: rst_n = 0 for 2 cycles, release; read all 32 addresses -> every rd = 0x00000000, any_busy = 0.
- Dual write, distinct addresses: we0 to x3 = 0xFEEDABBA and we1 to x7 = 0x12345678 in the same cycle; next cycle ra = {7,3} -> rd = {0x12345678, 0xFEEDABBA}.
- Write collision: we0 and we1 both to x5, wd0 = 0xAAAA0000, wd1 = 0x5555FFFF -> x5 reads 0xAAAA0000.
- Zero register: we0 to x0 = 0xFFFFFFFF and set_busy on x0 -> x0 reads 0, rd_busy = 0, any_busy = 0.
- Scoreboard:
  - set_busy x9 -> next cycle rd_busy = 1 on the port reading x9, any_busy = 1.
  - Then set_busy x9 together with we1 to x9 = 0x00000042 -> x9 stays busy and reads 0x42.
  - Then we1 to x9 alone -> busy clears.
- Bypass and async reset:
  - With REGFILE_BYPASS_EN, we0 to x4 = 0xCAFEF00D and ra[0] = 4 in the same cycle -> rd[0] = 0xCAFEF00D before the edge.
  - Without the macro, rd[0] = old value in that cycle.
  - Then pull rst_n low mid-cycle -> rd drops to 0 immediately, without waiting for a clock edge.
